// File: rtl/rram_pkg.sv
// Shared definitions for the RRAM command controller: command codes,
// FSM states, array_op bit positions and status bit indices.
package rram_pkg;

  localparam int unsigned CMD_PKG_W = 4;

  localparam logic [CMD_PKG_W-1:0] CMD_NOP        = 4'h0;
  localparam logic [CMD_PKG_W-1:0] CMD_READ       = 4'h1;
  localparam logic [CMD_PKG_W-1:0] CMD_WRITE      = 4'h2;
  localparam logic [CMD_PKG_W-1:0] CMD_ERASE      = 4'h3;
  localparam logic [CMD_PKG_W-1:0] CMD_CLR_STATUS = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_EXEC      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam int unsigned OP_W     = 3;
  localparam int unsigned OP_READ  = 0;
  localparam int unsigned OP_WRITE = 1;
  localparam int unsigned OP_ERASE = 2;

  localparam int unsigned STS_W       = 8;
  localparam int unsigned STS_STICKY_W = 4;
  localparam int unsigned STS_READY   = 7;
  localparam int unsigned STS_DROP    = 3;
  localparam int unsigned STS_ILLEGAL = 2;
  localparam int unsigned STS_TIMEOUT = 1;
  localparam int unsigned STS_FAIL    = 0;

  // One-hot array operation for an array-touching command; zero otherwise.
  function automatic logic [OP_W-1:0] op_onehot(input logic [CMD_PKG_W-1:0] cmd);
    logic [OP_W-1:0] op;
    op = '0;
    case (cmd)
      CMD_READ:  op[OP_READ]  = 1'b1;
      CMD_WRITE: op[OP_WRITE] = 1'b1;
      CMD_ERASE: op[OP_ERASE] = 1'b1;
      default:   op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rram_cmd_controller_sync_pulse.sv
// N-stage level synchroniser with an optional registered rising-edge pulse.
module sync_pulse #(
  parameter int unsigned STAGES  = 2,
  parameter bit          EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(async_in);
    end
  end

  assign sync_out = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic rise_q;

      // Registered one-cycle pulse on a rising synchronised level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          rise_q <= 1'b0;
        end else begin
          prev_q <= sync_out;
          rise_q <= sync_out & ~prev_q;
        end
      end

      assign rise = rise_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rram_cmd_controller.sv
// Sequences accepted RRAM commands (address, data, array execution,
// completion) and maintains the host ready/busy line and sticky status.
module rram_cmd_controller
  import rram_pkg::*;
#(
  parameter int unsigned CMD_W       = 4,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] command,
  input  logic             command_register_ready,
  input  logic             addr_ready,
  input  logic             data_ready,
  input  logic             array_done,
  output logic             array_en,
  output logic [OP_W-1:0]  array_op,
  output logic             rb_n,
  output logic [STS_W-1:0] status
);

  state_e                  state;
  logic [CMD_W-1:0]        cmd_q;
  logic [TO_W-1:0]         timer_q;
  logic [STS_STICKY_W-1:0] sticky_q;

  logic cmd_evt;
  logic cmd_sync;
  logic addr_sync;
  logic data_sync;
  logic addr_rise;
  logic data_rise;
  logic unused_rise;

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_cmd (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (command_register_ready),
    .sync_out (cmd_sync),
    .rise     (cmd_evt)
  );

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (addr_ready),
    .sync_out (addr_sync),
    .rise     (addr_rise)
  );

  sync_pulse #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_data (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (data_ready),
    .sync_out (data_sync),
    .rise     (data_rise)
  );

  // Only the command path needs an edge; the level of cmd_sync is not used.
  assign unused_rise = addr_rise ^ data_rise ^ cmd_sync;

  // Command sequencing FSM with registered array/ready outputs and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      timer_q  <= '0;
      array_en <= 1'b0;
      array_op <= '0;
      rb_n     <= 1'b1;
      sticky_q <= '0;
    end else begin
      // A command arriving while busy is discarded but recorded.
      if (cmd_evt && (state != ST_IDLE)) begin
        sticky_q[STS_DROP] <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_evt) begin
            cmd_q <= command;
            case (command)
              CMD_W'(CMD_READ),
              CMD_W'(CMD_WRITE),
              CMD_W'(CMD_ERASE): begin
                state <= ST_WAIT_ADDR;
                rb_n  <= 1'b0;
              end
              CMD_W'(CMD_CLR_STATUS): sticky_q <= '0;
              CMD_W'(CMD_NOP):        ;
              default:                sticky_q[STS_ILLEGAL] <= 1'b1;
            endcase
          end
        end

        ST_WAIT_ADDR: begin
          if (addr_sync) begin
            if (cmd_q == CMD_W'(CMD_WRITE)) begin
              state <= ST_WAIT_DATA;
            end else begin
              state    <= ST_EXEC;
              array_en <= 1'b1;
              array_op <= op_onehot(CMD_PKG_W'(cmd_q));
              timer_q  <= '0;
            end
          end
        end

        ST_WAIT_DATA: begin
          if (data_sync) begin
            state    <= ST_EXEC;
            array_en <= 1'b1;
            array_op <= op_onehot(CMD_PKG_W'(cmd_q));
            timer_q  <= '0;
          end
        end

        ST_EXEC: begin
          // Completion takes priority over a coincident timeout.
          if (array_done) begin
            state    <= ST_DONE;
            array_en <= 1'b0;
            array_op <= '0;
          end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
            state                 <= ST_DONE;
            array_en              <= 1'b0;
            array_op              <= '0;
            sticky_q[STS_TIMEOUT] <= 1'b1;
            sticky_q[STS_FAIL]    <= 1'b1;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TO_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          rb_n  <= 1'b1;
        end

        default: begin
          state    <= ST_IDLE;
          array_en <= 1'b0;
          array_op <= '0;
          rb_n     <= 1'b1;
        end
      endcase
    end
  end

  assign status = {rb_n, 3'b000, sticky_q};

endmodule

// File: tb/tb_rram_cmd_controller.sv
// Directed self-checking bench for rram_cmd_controller.
module tb_rram_cmd_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] command;
  logic       command_register_ready;
  logic       addr_ready;
  logic       data_ready;
  logic       array_done;
  logic       array_en;
  logic [2:0] array_op;
  logic       rb_n;
  logic [7:0] status;

  int n_checks;
  int n_errors;

  rram_cmd_controller #(
    .CMD_W       (4),
    .TO_W        (8),
    .TIMEOUT     (200),
    .SYNC_STAGES (2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .command                (command),
    .command_register_ready (command_register_ready),
    .addr_ready             (addr_ready),
    .data_ready             (data_ready),
    .array_done             (array_done),
    .array_en               (array_en),
    .array_op               (array_op),
    .rb_n                   (rb_n),
    .status                 (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until array_en is observed high.
  task automatic wait_en(input string tag, input int max);
    int n;
    n = 0;
    while (array_en !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(array_en), 32'd1);
  endtask

  task automatic pulse_done();
    array_done = 1'b1;
    @(negedge clk);
    array_done = 1'b0;
  endtask

  task automatic issue(input logic [3:0] cmd);
    command = cmd;
    command_register_ready = 1'b1;
  endtask

  task automatic release_all();
    command_register_ready = 1'b0;
    addr_ready = 1'b0;
    data_ready = 1'b0;
    cycles(5);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    command = 4'h0;
    command_register_ready = 1'b0;
    addr_ready = 1'b0;
    data_ready = 1'b0;
    array_done = 1'b0;

    // Reset and idle
    cycles(3);
    check("rst_status", 32'(status), 32'h80);
    check("rst_rb_n", 32'(rb_n), 32'd1);
    check("rst_en", 32'(array_en), 32'd0);
    check("rst_op", 32'(array_op), 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // READ flow
    issue(4'h1);
    addr_ready = 1'b1;
    cycles(3);
    check("read_rb_before", 32'(rb_n), 32'd1);
    cycles(1);
    check("read_rb_fall", 32'(rb_n), 32'd0);
    wait_en("read_en", 10);
    for (int i = 1; i <= 5; i++) begin
      check("read_op", 32'(array_op), 32'b001);
      if (i == 5) array_done = 1'b1;
      @(negedge clk);
    end
    array_done = 1'b0;
    check("read_done_en", 32'(array_en), 32'd0);
    check("read_done_op", 32'(array_op), 32'd0);
    check("read_done_rb", 32'(rb_n), 32'd0);
    cycles(1);
    check("read_rb_rise", 32'(rb_n), 32'd1);
    check("read_status", 32'(status), 32'h80);
    release_all();

    // WRITE stalls for data
    issue(4'h2);
    addr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("write_wait_en", 32'(array_en), 32'd0);
    end
    check("write_wait_busy", 32'(rb_n), 32'd0);
    data_ready = 1'b1;
    wait_en("write_en", 10);
    check("write_op", 32'(array_op), 32'b010);
    pulse_done();
    cycles(1);
    check("write_rb_rise", 32'(rb_n), 32'd1);
    check("write_status", 32'(status), 32'h80);
    release_all();

    // ERASE timeout
    issue(4'h3);
    addr_ready = 1'b1;
    wait_en("erase_en", 10);
    check("erase_op", 32'(array_op), 32'b100);
    cnt = 0;
    while (array_en === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("erase_en_len", 32'(cnt), 32'd200);
    check("erase_status_busy", 32'(status), 32'h03);
    cycles(1);
    check("erase_status_idle", 32'(status), 32'h83);
    release_all();
    issue(4'h7);
    cycles(6);
    check("clr_status", 32'(status), 32'h80);
    check("clr_rb_n", 32'(rb_n), 32'd1);
    release_all();

    // Dropped command during EXEC
    issue(4'h1);
    addr_ready = 1'b1;
    wait_en("drop_en", 10);
    command_register_ready = 1'b0;
    cycles(3);
    issue(4'h2);
    cycles(5);
    check("drop_status_busy", 32'(status), 32'h08);
    check("drop_still_en", 32'(array_en), 32'd1);
    check("drop_still_op", 32'(array_op), 32'b001);
    pulse_done();
    cycles(1);
    check("drop_rb_rise", 32'(rb_n), 32'd1);
    check("drop_status_idle", 32'(status), 32'h88);
    release_all();
    issue(4'h7);
    cycles(6);
    check("drop_clr", 32'(status), 32'h80);
    release_all();

    // Illegal command
    issue(4'hA);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("illegal_rb_n", 32'(rb_n), 32'd1);
    end
    check("illegal_status", 32'(status), 32'h84);
    release_all();

    // Asynchronous reset during EXEC
    issue(4'h1);
    addr_ready = 1'b1;
    wait_en("arst_en", 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en_clr", 32'(array_en), 32'd0);
    check("arst_rb_n", 32'(rb_n), 32'd1);
    check("arst_status", 32'(status), 32'h80);
    check("arst_op", 32'(array_op), 32'd0);
    release_all();
    rst_n = 1'b1;
    cycles(5);
    check("post_rst_idle", 32'(rb_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rram_cmd_controller.md
Name: rram_cmd_controller

Overview:
- Control FSM directly downstream of the command register. It consumes `command[3:0]` and `command_register_ready`.
- It sequences each accepted RRAM operation: wait for address, wait for write data, drive the array operation, then wait for completion.
- Drives the host-visible ready/busy line and a sticky status register.
- Sits between the host-interface registers (command, address, data) and the RRAM array driver.

Parameters:
- CMD_W, 4, command width (matches command register output)
- TO_W, 8, width of the execution timeout counter
- TIMEOUT, 200, max cycles spent in EXEC before a failure is declared; must be < 2^TO_W
- SYNC_STAGES, 2, flop stages used to synchronise `command_register_ready`, `addr_ready` and `data_ready`

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- command  in  CMD_W  latched command from the command register; stable while `command_register_ready`=1
- command_register_ready  in  1  asynchronous level; rises when CLE falls, cleared by CE
- addr_ready  in  1  address register holds a complete address (asynchronous level)
- data_ready  in  1  write-data register is loaded (asynchronous level)
- array_done  in  1  array driver completion pulse, synchronous to `clk`
- array_en  out  1  level; high for the whole EXEC state
- array_op  out  3  one-hot {erase, write, read}; valid while `array_en`=1, else 0
- rb_n  out  1  ready/busy, 1 = ready
- status  out  8  [7] = ready (mirror of `rb_n`); [3] = cmd_dropped; [2] = illegal_cmd; [1] = timeout; [0] = fail; [6:4] = 0

Behaviour:
- Reset (async, `rst_n`=0):
  - state = IDLE, `array_en` = 0, `array_op` = 0, `rb_n` = 1, `status` = 8'h80.
  - Synchroniser flops, edge-detect flop, captured command `cmd_q` and the timer all clear.
  - Reset mid-operation aborts immediately; no completion is reported.
- Synchronisation:
  - `command_register_ready`, `addr_ready` and `data_ready` each pass through SYNC_STAGES flops.
  - `cmd_evt` = rising edge of the synchronised ready, one cycle wide.
  - `command` is sampled into `cmd_q` on the `cmd_evt` cycle.
- Command encoding:
  - 4'h1 READ, 4'h2 WRITE, 4'h3 ERASE, 4'h7 CLR_STATUS, 4'h0 NOP.
  - Any other value is illegal.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, EXEC, DONE.
- IDLE, on `cmd_evt`:
  - READ / ERASE → WAIT_ADDR.
  - WRITE → WAIT_ADDR.
  - CLR_STATUS → clears `status[3:0]`, stays IDLE.
  - NOP → ignored.
  - Illegal command → sets `status[2]`, stays IDLE.
- WAIT_ADDR, once `addr_ready` (synchronised) = 1:
  - WRITE → WAIT_DATA.
  - Otherwise → EXEC.
- WAIT_DATA: on `data_ready` = 1 → EXEC.
- EXEC:
  - `array_en` = 1; `array_op` one-hot from `cmd_q`.
  - Timer clears on entry and increments each cycle.
  - `array_done` = 1 → DONE.
  - Else timer == TIMEOUT-1 → set `status[1]` and `status[0]`, → DONE.
  - If `array_done` and the timeout arrive in the same cycle, `array_done` wins: no fail.
- DONE: one cycle; `array_en` = 0; → IDLE.
- `rb_n`:
  - Registered output; 0 in every state except IDLE.
  - Falls in the cycle after the accepting `cmd_evt`.
  - Rises in the cycle after DONE.
- `cmd_evt` while not IDLE: command discarded, `status[3]` set, FSM unaffected (CLR_STATUS is also discarded while busy).
- Sticky bits `status[3:0]` clear only by reset or an accepted CLR_STATUS.
- Timer saturates; it never wraps.
- Latency: `command_register_ready` rise → `rb_n` low = SYNC_STAGES + 2 clk edges.

Decomposition:
- Shared package `rram_pkg` holds:
  - command codes (CMD_NOP, CMD_READ, CMD_WRITE, CMD_ERASE, CMD_CLR_STATUS);
  - FSM state encoding;
  - `array_op` bit positions;
  - status bit indices.
- One sub-module: `sync_pulse`, an N-stage synchroniser with optional rising-edge output. It is instantiated three times; only the command instance uses the edge output.

Test Plan:
- Reset, then idle: `rst_n` low 3 cycles → `status`=8'h80, `rb_n`=1, `array_en`=0, `array_op`=0.
- READ flow: `command`=4'h1, ready rises, `addr_ready`=1, `array_done` pulse after 5 EXEC cycles:
  - `rb_n` low 4 cycles after the ready rise;
  - `array_op`=3'b001 for exactly 5 cycles;
  - `rb_n` high 2 cycles after `array_done`;
  - `status`=8'h80.
- WRITE waits for data: `command`=4'h2, `addr_ready`=1, `data_ready` held 0 for 20 cycles → FSM stays in WAIT_DATA with `array_en`=0; after `data_ready`=1, `array_op`=3'b010.
- Timeout: ERASE with no `array_done` → `array_en` high exactly 200 cycles, then `status`=8'h03 while busy and 8'h83 after return to IDLE; CLR_STATUS then gives 8'h80.
- Dropped and illegal commands:
  - second ready edge during EXEC → `status[3]`=1 and the operation completes normally;
  - `command`=4'hA in IDLE → `status[2]`=1 and `rb_n` stays 1.
- Reset mid-EXEC: assert `rst_n`=0 with `array_en`=1 → `array_en`, `rb_n` and `status` return to their reset values asynchronously, before the next clock edge.
